// File: rtl/bist_engine.sv
// bist_engine: logic BIST controller. An LFSR drives stimulus into the core,
// and a 16-bit MISR compacts the core's registered response. The final
// signature is compared against a golden value.
module bist_engine #(
  parameter logic [15:0] NUM_PATTERNS = 16'd255,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5,
  parameter logic [15:0] GOLDEN       = 16'h0000
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic [3:0]  Y,
  output logic [3:0]  X,
  output logic        SM_RESET,
  output logic        BIST_ACTIVE,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] SIGNATURE
);

  // A pattern count of zero still runs one pattern. An all-zero seed would
  // lock the LFSR, so it is replaced with 1.
  localparam logic [15:0] N_EFF    = (NUM_PATTERNS == 16'd0) ? 16'd1 : NUM_PATTERNS;
  localparam logic [7:0]  SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_CMPL  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_lfsr;
  logic [15:0] r_misr;
  logic [15:0] r_cnt;
  logic        r_done;
  logic        r_pass;
  logic        w_lfsr_fb;
  logic [15:0] w_misr_next;
  logic        w_last_pattern;

  assign w_lfsr_fb      = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_misr_next    = {r_misr[14:0], 1'b0}
                        ^ (r_misr[15] ? 16'h1021 : 16'h0000)
                        ^ {12'h000, Y};
  // The counter holds the number of RUN cycles already completed, so the
  // last RUN cycle is the one in which it reads N-1.
  assign w_last_pattern = (r_cnt == (N_EFF - 16'd1));

  // State register
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; ABORT overrides START everywhere
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (START && !ABORT) begin
          w_state_next = S_INIT;
        end
      end
      S_INIT: begin
        w_state_next = ABORT ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (ABORT) begin
          w_state_next = S_IDLE;
        end else if (w_last_pattern) begin
          w_state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_state_next = ABORT ? S_IDLE : S_CMPL;
      end
      S_CMPL: begin
        if (ABORT) begin
          w_state_next = S_IDLE;
        end else if (START) begin
          w_state_next = S_INIT;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Decoded outputs from the current state
  always_comb begin
    X           = 4'h0;
    SM_RESET    = 1'b0;
    BIST_ACTIVE = 1'b0;
    BUSY        = 1'b0;
    case (r_state)
      S_INIT: begin
        SM_RESET    = 1'b1;
        BIST_ACTIVE = 1'b1;
        BUSY        = 1'b1;
      end
      S_RUN: begin
        X           = r_lfsr[3:0];
        BIST_ACTIVE = 1'b1;
        BUSY        = 1'b1;
      end
      S_FLUSH: begin
        BIST_ACTIVE = 1'b1;
        BUSY        = 1'b1;
      end
      default: begin
        X = 4'h0;
      end
    endcase
  end

  // Pattern generator, response compactor and pattern counter. The update
  // depends only on the current state, so an aborted cycle still compacts
  // its response and the partial signature reflects it.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_lfsr <= SEED_EFF;
      r_misr <= 16'h0000;
      r_cnt  <= 16'h0000;
    end else begin
      case (r_state)
        S_INIT: begin
          r_lfsr <= SEED_EFF;
          r_misr <= 16'h0000;
          r_cnt  <= 16'h0000;
        end
        S_RUN: begin
          r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
          r_misr <= w_misr_next;
          r_cnt  <= r_cnt + 16'd1;
        end
        S_FLUSH: begin
          r_misr <= w_misr_next;
        end
        default: begin
          r_misr <= r_misr;
        end
      endcase
    end
  end

  // Registered completion flags. Both are valid exactly while in CMPL.
  // PASS is judged on entry to CMPL against the final signature.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_done <= (w_state_next == S_CMPL);
      if (w_state_next != S_CMPL) begin
        r_pass <= 1'b0;
      end else if (r_state == S_FLUSH) begin
        r_pass <= (w_misr_next == GOLDEN);
      end
    end
  end

  assign DONE      = r_done;
  assign PASS      = r_pass;
  assign SIGNATURE = r_misr;

endmodule

// File: doc/bist_engine.md
BIST_ENGINE -- requirements
Module: bist_engine

Interface
REQ-001 SHALL have parameter NUM_PATTERNS, default 16'd255: number of RUN cycles per test; value 0 SHALL behave as 1.
REQ-002 SHALL have parameter LFSR_SEED, default 8'hA5: LFSR load value; 8'h00 SHALL be replaced by 8'h01.
REQ-003 SHALL have parameter GOLDEN, default 16'h0000: expected final signature.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port START, input, 1 bit: run request, sampled each cycle.
REQ-007 SHALL have port ABORT, input, 1 bit: cancel the run in progress.
REQ-008 SHALL have port Y, input, 4 bits: core-logic state, already registered by the core on clk.
REQ-009 SHALL have port X, output, 4 bits: stimulus to the core-logic input.
REQ-010 SHALL have port SM_RESET, output, 1 bit: core-logic state reset request.
REQ-011 SHALL have port BIST_ACTIVE, output, 1 bit: core clock and enable select (drives RUNBIST_SELECT).
REQ-012 SHALL have port BUSY, output, 1 bit: run in progress.
REQ-013 SHALL have port DONE, output, 1 bit: run complete.
REQ-014 SHALL have port PASS, output, 1 bit: signature equals GOLDEN.
REQ-015 SHALL have port SIGNATURE, output, 16 bits: MISR contents.

Function
REQ-016 SHALL implement states IDLE, INIT, RUN, FLUSH and CMPL.
REQ-017 SHALL go IDLE->INIT when START=1 and ABORT=0; IDLE SHALL otherwise hold.
REQ-018 INIT SHALL last 1 cycle: SM_RESET=1, LFSR<=seed, MISR<=0, pattern counter<=0; then RUN.
REQ-019 In RUN, X SHALL equal LFSR[3:0]; X SHALL be 4'h0 in every other state.
REQ-020 In RUN, each cycle SHALL advance the LFSR: fb=L[7]^L[5]^L[4]^L[3], L<={L[6:0],fb}.
REQ-021 In RUN, each cycle SHALL increment the counter; RUN SHALL exit to FLUSH after exactly NUM_PATTERNS cycles (16-bit counter, no wrap).
REQ-022 In every RUN and FLUSH cycle, the MISR SHALL update M<={M[14:0],1'b0}^(M[15]?16'h1021:0)^{12'h000,Y}, i.e. NUM_PATTERNS+1 updates; FLUSH captures the response to the last pattern.
REQ-023 FLUSH SHALL last 1 cycle, then CMPL.
REQ-024 In CMPL: DONE=1 and PASS=(SIGNATURE==GOLDEN), both registered, stable until CMPL is left.
REQ-025 From CMPL, START=1 SHALL go to INIT (clearing DONE/PASS); ABORT=1 SHALL go to IDLE.
REQ-026 BUSY and BIST_ACTIVE SHALL be 1 exactly in INIT, RUN and FLUSH.
REQ-027 Latency: START accepted in cycle 0 -> INIT in cycle 1, RUN in cycles 2..N+1, FLUSH in cycle N+2, DONE=1 from cycle N+3.
REQ-028 START while BUSY SHALL be ignored.
REQ-029 ABORT=1 in INIT/RUN/FLUSH SHALL force IDLE next cycle with DONE=PASS=0; SIGNATURE retains its partial value.
REQ-030 START and ABORT together SHALL give ABORT priority in every state.
REQ-031 SIGNATURE SHALL hold its value outside RUN/FLUSH until the next INIT.

Reset
REQ-032 RESET_N=0 SHALL immediately (asynchronously) force IDLE, X=0, SM_RESET=0, BIST_ACTIVE=0, BUSY=0, DONE=0, PASS=0, SIGNATURE=0, LFSR=seed, counter=0.
REQ-033 Reset assertion mid-run SHALL abort with no DONE; after release the block SHALL wait in IDLE for START.

Verification
REQ-034 Reset, then idle 10 cycles -> all outputs 0, BUSY=0.
REQ-035 With NUM_PATTERNS=1, LFSR_SEED=8'h01, GOLDEN=16'h0002 and the real core attached, START pulse -> X=4'h1 in cycle 2; SIGNATURE=16'h0002, DONE=1, PASS=1 from cycle 4.
REQ-036 With NUM_PATTERNS=2, LFSR_SEED=8'h01 -> X=1 then 2; Y=2 then 9; SIGNATURE=16'h000D; DONE at cycle 5; with GOLDEN=0, PASS=0.
REQ-037 Default parameters; ABORT asserted in RUN cycle 50 -> IDLE next cycle, BUSY=0, DONE=0; a subsequent START rerun reproduces the full-run signature.
REQ-038 START held continuously from reset -> back-to-back runs; each CMPL lasts 1 cycle; all signatures identical.
REQ-039 RESET_N pulsed low mid-RUN, asynchronously to clk -> outputs clear without waiting for a clock edge; no DONE.
